// File: rtl/fetch_pkg.sv
// Shared types and defaults for the byte-wise instruction fetch unit.
// Optional last-fetch hit buffer is enabled by defining FETCH_HIT_BUF_EN.
package fetch_pkg;

   localparam int unsigned def_size_addr  = 8;
   localparam int unsigned def_word_bytes = 2;

`ifdef FETCH_HIT_BUF_EN
   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_issue = 3'd1,
      st_wait  = 3'd2,
      st_done  = 3'd3,
      st_hit   = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_issue = 3'd1,
      st_wait  = 3'd2,
      st_done  = 3'd3
   } state_e;
`endif

endpackage

// File: rtl/fetch_unit_if.sv
// CPU-side request/response and memory-side read bus of the fetch unit.
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int unsigned size_addr  = def_size_addr,
   parameter int unsigned word_bytes = def_word_bytes
);
   logic                    start;
   logic [size_addr-1:0]    pc;
   logic                    busy;
   logic                    done;
   logic [8*word_bytes-1:0] word;
   logic                    mem_read;
   logic [size_addr-1:0]    mem_address;
   logic                    mem_ready;
   logic [7:0]              mem_data;

   // Fetch unit side
   modport master (
      input  start, pc, mem_ready, mem_data,
      output busy, done, word, mem_read, mem_address
   );

   // CPU plus memory side
   modport slave (
      output start, pc, mem_ready, mem_data,
      input  busy, done, word, mem_read, mem_address
   );
endinterface

// File: rtl/fetch_unit.sv
// Byte-wise fetch unit: reads word_bytes consecutive bytes from a byte-wide
// read-only memory and assembles them little-endian. With FETCH_HIT_BUF_EN
// defined, a one-entry buffer returns a repeat fetch of the same pc without
// touching memory.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned size_addr  = def_size_addr,
   parameter int unsigned word_bytes = def_word_bytes
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);

   localparam int unsigned word_w = 8 * word_bytes;
   localparam int unsigned k_w    = (word_bytes > 1) ? $clog2(word_bytes) : 1;
   localparam logic [k_w-1:0] k_last = k_w'(word_bytes - 1);

   state_e               state_q, state_d;
   logic [size_addr-1:0] base_q,  base_d;
   logic [size_addr-1:0] addr_q,  addr_d;
   logic [k_w-1:0]       k_q,     k_d;
   logic [word_w-1:0]    asm_q,   asm_d;
   logic [word_w-1:0]    word_q,  word_d;
   logic                 rd_q,    rd_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;
`ifdef FETCH_HIT_BUF_EN
   logic [size_addr-1:0] tag_q,   tag_d;
   logic                 valid_q, valid_d;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      addr_d  = addr_q;
      k_d     = k_q;
      asm_d   = asm_q;
      word_d  = word_q;
      rd_d    = 1'b0;
      done_d  = 1'b0;
`ifdef FETCH_HIT_BUF_EN
      tag_d   = tag_q;
      valid_d = valid_q;
`endif
      case (state_q)
         st_idle: begin
            // A start coinciding with the done pulse belongs to the old fetch
            if (bus.start && !done_q) begin
               base_d = bus.pc;
               k_d    = '0;
`ifdef FETCH_HIT_BUF_EN
               if (valid_q && (tag_q == bus.pc)) begin
                  state_d = st_hit;
                  asm_d   = word_q;
               end else begin
                  state_d = st_issue;
                  rd_d    = 1'b1;
                  addr_d  = bus.pc;
               end
`else
               state_d = st_issue;
               rd_d    = 1'b1;
               addr_d  = bus.pc;
`endif
            end
         end
         st_issue: begin
            state_d = st_wait;
         end
         st_wait: begin
            if (bus.mem_ready) begin
               for (int unsigned i = 0; i < word_bytes; i++) begin
                  if (k_q == k_w'(i)) begin
                     asm_d[8*i +: 8] = bus.mem_data;
                  end
               end
               if (k_q == k_last) begin
                  state_d = st_done;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = st_issue;
                  rd_d    = 1'b1;
                  addr_d  = base_q + size_addr'(k_d);
               end
            end
         end
`ifdef FETCH_HIT_BUF_EN
         st_hit: begin
            state_d = st_done;
         end
`endif
         st_done: begin
            state_d = st_idle;
            done_d  = 1'b1;
            word_d  = asm_q;
`ifdef FETCH_HIT_BUF_EN
            tag_d   = base_q;
            valid_d = 1'b1;
`endif
         end
         default: begin
            state_d = st_idle;
         end
      endcase
`ifdef FETCH_HIT_BUF_EN
      busy_d = (state_d == st_issue) || (state_d == st_wait) || (state_d == st_hit);
`else
      busy_d = (state_d == st_issue) || (state_d == st_wait);
`endif
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= st_idle;
         base_q  <= '0;
         addr_q  <= '0;
         k_q     <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FETCH_HIT_BUF_EN
         tag_q   <= '0;
         valid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         k_q     <= k_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef FETCH_HIT_BUF_EN
         tag_q   <= tag_d;
         valid_q <= valid_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.word        = word_q;
   assign bus.mem_read    = rd_q;
   assign bus.mem_address = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable byte memory and
// a scoreboard of expected words/latencies. Define FETCH_HIT_BUF_EN to
// exercise the hit buffer.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_unit_if #(.size_addr(8), .word_bytes(2)) bus ();

   fetch_unit #(.size_addr(8), .word_bytes(2)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          cyc0;
      int          lat;
   } sb_t;

   sb_t        sb_q[$];
   logic [7:0] mem [256];
   logic [7:0] addr_log[$];
   logic [3:0] vpipe = '0;
   logic [7:0] apipe [4];
   int         mem_lat = 1;
   int         cyc = 0;
   int         rd_cnt = 0;
   int         done_cnt = 0;
   int         consec = 0;
   logic       prev_rd = 1'b0;
   int         checks = 0;
   int         failures = 0;

   // Memory: mem_ready is mem_read delayed by mem_lat registered cycles
   always @(posedge clk) begin
      vpipe    <= {vpipe[2:0], bus.mem_read};
      apipe[0] <= bus.mem_address;
      apipe[1] <= apipe[0];
      apipe[2] <= apipe[1];
      apipe[3] <= apipe[2];
      cyc      <= cyc + 1;
   end
   assign bus.mem_ready = vpipe[mem_lat-1];
   assign bus.mem_data  = mem[apipe[mem_lat-1]];

   // Bus monitor on the inactive edge
   always @(negedge clk) begin
      if (bus.mem_read) begin
         rd_cnt++;
         addr_log.push_back(bus.mem_address);
      end
      if (bus.mem_read && prev_rd) consec++;
      prev_rd = bus.mem_read;
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mem_path_lat();
      return 2 * (mem_lat + 1) + 1;
   endfunction

   // Drive a start and record the expected outcome in the scoreboard
   task automatic run_fetch(input logic [7:0] p, input int lat, input bit hold);
      sb_t        e;
      logic [7:0] p1;
      p1 = p + 8'd1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.pc    = p;
      @(posedge clk);
      #1;
      e.word = {mem[p1], mem[p]};
      e.cyc0 = cyc;
      e.lat  = lat;
      sb_q.push_back(e);
      if (!hold) bus.start = 1'b0;
   endtask

   // Bounded wait for done, then compare against the scoreboard head
   task automatic wait_done(input string tag, input bit hold);
      int  n;
      sb_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
      end while (!bus.done && n < 40);
      if (!bus.done) begin
         chk({tag, "_timeout"}, 32'(bus.done), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_word"}, 32'(bus.word), 32'(e.word));
         chk({tag, "_lat"}, 32'(cyc - e.cyc0), 32'(e.lat));
         chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
      end
      if (hold) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
   endtask

   initial begin
      int rd0;
      int dn0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
      mem[8'h10] = 8'h34; mem[8'h11] = 8'h12; mem[8'h12] = 8'h77;
      mem[8'hFF] = 8'hAA; mem[8'h00] = 8'h55;
      mem[8'h30] = 8'hC3; mem[8'h31] = 8'h3C;
      mem[8'h20] = 8'h9E; mem[8'h21] = 8'hE9;
      bus.start = 1'b0;
      bus.pc    = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_word", 32'(bus.word), 0);
      chk("rst_rd", 32'(bus.mem_read), 0);
      chk("rst_addr", 32'(bus.mem_address), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic fetch at 0x10
      addr_log.delete();
      rd0 = rd_cnt;
      run_fetch(8'h10, mem_path_lat(), 1'b0);
      wait_done("basic", 1'b0);
      chk("basic_a0", 32'(addr_log[0]), 32'h10);
      chk("basic_a1", 32'(addr_log[1]), 32'h11);
      chk("basic_rds", 32'(rd_cnt - rd0), 2);

      // Address wrap at 0xFF
      addr_log.delete();
      run_fetch(8'hFF, mem_path_lat(), 1'b0);
      wait_done("wrap", 1'b0);
      chk("wrap_a1", 32'(addr_log[1]), 32'h00);
      chk("wrap_word", 32'(bus.word), 32'h55AA);

      // Slow memory: three cycles per byte
      mem_lat = 3;
      rd0 = rd_cnt;
      run_fetch(8'h30, mem_path_lat(), 1'b0);
      wait_done("slow", 1'b0);
      chk("slow_rds", 32'(rd_cnt - rd0), 2);
      mem_lat = 1;
      repeat (2) @(negedge clk);

      // start held through the fetch and through the done cycle
      rd0 = rd_cnt;
      dn0 = done_cnt;
      run_fetch(8'h11, mem_path_lat(), 1'b1);
      wait_done("hold", 1'b1);
      repeat (8) @(negedge clk);
      chk("hold_dones", 32'(done_cnt - dn0), 1);
      chk("hold_rds", 32'(rd_cnt - rd0), 2);
      chk("hold_idle", 32'(bus.busy), 0);

      // Reset while waiting on slow memory; its response arrives afterwards
      mem_lat = 3;
      dn0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.pc    = 8'h40;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_word", 32'(bus.word), 0);
      chk("mid_rst_rd", 32'(bus.mem_read), 0);
      chk("mid_rst_addr", 32'(bus.mem_address), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_rst_dones", 32'(done_cnt - dn0), 0);
      chk("mid_rst_word2", 32'(bus.word), 0);
      mem_lat = 1;

      // Recovery fetch; hit buffer was invalidated by reset
      rd0 = rd_cnt;
      run_fetch(8'h10, mem_path_lat(), 1'b0);
      wait_done("recov", 1'b0);
      chk("recov_rds", 32'(rd_cnt - rd0), 2);

      // Repeat fetch of the same pc
      rd0 = rd_cnt;
`ifdef FETCH_HIT_BUF_EN
      run_fetch(8'h10, 2, 1'b0);
      wait_done("hit", 1'b0);
      chk("hit_rds", 32'(rd_cnt - rd0), 0);
      rd0 = rd_cnt;
      run_fetch(8'h20, mem_path_lat(), 1'b0);
      wait_done("miss", 1'b0);
      chk("miss_rds", 32'(rd_cnt - rd0), 2);
`else
      run_fetch(8'h10, mem_path_lat(), 1'b0);
      wait_done("again", 1'b0);
      chk("again_rds", 32'(rd_cnt - rd0), 2);
`endif

      repeat (3) @(negedge clk);
      chk("no_back_to_back_rd", 32'(consec), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter size_addr, default 8: width of the byte address on both the CPU and memory sides.
REQ-002 Parameter word_bytes, default 2: bytes assembled per fetch; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  CPU fetch request, sampled only in IDLE.
REQ-006 pc  input  size_addr  byte address of the first byte, sampled with start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse; word is valid from this cycle on.
REQ-009 word  output  8*word_bytes  assembled word, little-endian (the byte at pc is in [7:0]); held until the next done.
REQ-010 mem_read  output  1  read strobe to the byte-wide read-only memory.
REQ-011 mem_address  output  size_addr  byte address for mem_read.
REQ-012 mem_ready  input  1  memory response strobe; mem_data is valid while it is high.
REQ-013 mem_data  input  8  memory read data.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, plus HIT when the hit buffer is compiled in.
- IDLE: start=1 latches pc into base, clears byte index k to 0, and moves to ISSUE.
REQ-015 ISSUE SHALL last exactly one cycle with mem_read=1 and mem_address=base+k (modulo 2^size_addr), then move to WAIT.
- The address wraps: pc=0xFF with word_bytes=2 fetches bytes 0xFF and 0x00.
REQ-016 WAIT SHALL hold mem_read=0 and stay in WAIT until mem_ready=1; there is no timeout.
- On mem_ready=1, mem_data is captured into byte lane k.
- If k=word_bytes-1, go to DONE; otherwise increment k and go to ISSUE.
REQ-017 DONE SHALL assert done=1 for one cycle, copy the assembly register to word, and return to IDLE.
REQ-018 Against a memory whose mem_ready is mem_read delayed by one registered cycle, done SHALL be high exactly 2*word_bytes+1 cycles after the edge that sampled start (5 for the default).
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 mem_ready high outside WAIT SHALL be ignored.
REQ-021 mem_read SHALL never be high in two consecutive cycles.
REQ-022 busy SHALL be high in ISSUE, WAIT and HIT, and low in IDLE and DONE.
REQ-023 start in the same cycle that done is high SHALL be ignored; the block accepts a new start only in IDLE.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE, mem_read=0, mem_address=0, busy=0, done=0, word=0, k=0 and the hit buffer invalid.
REQ-025 Reset mid-fetch SHALL abandon the fetch with no done pulse; a mem_ready arriving after reset is released SHALL be ignored.

Configuration
REQ-026 Macro FETCH_HIT_BUF_EN SHALL control a one-entry last-fetch buffer.
- With the macro defined: the buffer holds a tag (base) and a valid bit, which is set at each DONE.
- A start whose pc equals the tag while valid=1 goes IDLE->HIT->DONE with no mem_read, so done follows 2 cycles after start.
- The memory is read-only, so the valid bit is cleared only by reset.
REQ-027 Without the macro: no tag or valid storage exists, no HIT state exists, and every fetch uses the memory.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the state enum typedef and the constants for the default address width and default word size.
REQ-029 The design SHALL be a single flat module with no sub-module; the byte-lane assembly register is inline.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, memory holding 0x34 at 0x10 and 0x12 at 0x11; start with pc=0x10 -> mem_address 0x10 then 0x11, done at cycle +5, word=0x1234.
- pc=0xFF, memory holding 0xAA at 0xFF and 0x55 at 0x00 -> the second read goes to address 0x00, word=0x55AA.
- mem_ready delayed 3 cycles per byte -> mem_read stays single-cycle and done arrives at cycle +9.
- start held high during a fetch -> exactly one done and 2 mem_read pulses.
- reset asserted in WAIT, then a late mem_ready -> no done, word=0, and the next fetch is correct.
- With FETCH_HIT_BUF_EN, fetch 0x10 twice -> the second done arrives at +2 with no mem_read and the same word; fetch 0x20 -> memory is used.
